// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with registered, mutually aligned outputs
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int CNT_W       = 11,
  parameter int SCALE_SHIFT = 1
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic [CNT_W-1:0] h_cnt_div,
  output logic [CNT_W-1:0] v_cnt_div,
  output logic             line_start,
  output logic             frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             vblank
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int EW       = CNT_W + 1;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_size_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 4) begin : g_shift_check
    $error("vga_timing_gen: SCALE_SHIFT out of range 0..4");
  end

  // Decode compares run one bit wider so sync end points equal to the total still fit.
  localparam logic [EW-1:0] H_ACT_C  = EW'(H_ACTIVE);
  localparam logic [EW-1:0] V_ACT_C  = EW'(V_ACTIVE);
  localparam logic [EW-1:0] HS_S_C   = EW'(HS_START);
  localparam logic [EW-1:0] HS_E_C   = EW'(HS_END);
  localparam logic [EW-1:0] VS_S_C   = EW'(VS_START);
  localparam logic [EW-1:0] VS_E_C   = EW'(VS_END);
  localparam logic [EW-1:0] H_LAST_C = EW'(H_TOTAL - 1);
  localparam logic [EW-1:0] V_LAST_C = EW'(V_TOTAL - 1);

  logic [CNT_W-1:0] h_pos;
  logic [CNT_W-1:0] v_pos;
  logic [EW-1:0]    h_ext;
  logic [EW-1:0]    v_ext;

  assign h_ext = {1'b0, h_pos};
  assign v_ext = {1'b0, v_pos};

  always_ff @(posedge pclk) begin
    if (reset) begin
      h_pos <= '0;
      v_pos <= '0;
    end else if (pix_en) begin
      if (h_ext == H_LAST_C) begin
        h_pos <= '0;
        v_pos <= (v_ext == V_LAST_C) ? '0 : v_pos + CNT_W'(1);
      end else begin
        h_pos <= h_pos + CNT_W'(1);
      end
    end
  end

  logic             h_vis;
  logic             v_vis;
  logic             hs_act;
  logic             vs_act;
  logic             origin;
  logic [CNT_W-1:0] hc_d;
  logic [CNT_W-1:0] vc_d;

  always_comb begin
    h_vis  = h_ext < H_ACT_C;
    v_vis  = v_ext < V_ACT_C;
    hs_act = (h_ext >= HS_S_C) && (h_ext < HS_E_C);
    vs_act = (v_ext >= VS_S_C) && (v_ext < VS_E_C);
    origin = (h_pos == '0) && (v_pos == '0);
    hc_d   = h_vis ? h_pos : '0;
    vc_d   = v_vis ? v_pos : '0;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      valid       <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_cnt_div   <= '0;
      v_cnt_div   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (pix_en) begin
      hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      valid       <= h_vis && v_vis;
      h_cnt       <= hc_d;
      v_cnt       <= vc_d;
      h_cnt_div   <= hc_d >> SCALE_SHIFT;
      v_cnt_div   <= vc_d >> SCALE_SHIFT;
      line_start  <= (h_pos == '0);
      frame_start <= origin;
      vblank      <= !v_vis;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Bumped in the same enabled cycle that loads frame_start, so both appear together.
  always_ff @(posedge pclk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (pix_en && origin) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
